// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from an 8-bit FIFO and transmits them as 8N1 UART
// frames (LSB first), keeping a modulo-256 count of completed frames.
module fifo_uart_drain #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,        // active-high asynchronous reset despite the name
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        byte_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [7:0] TIMER_RELOAD = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT     = 3'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [7:0]        bit_timer;
  logic [2:0]        bit_idx;

  // Pop strobe decoded straight from the state register: exactly one REQ cycle per frame
  assign fifo_rd_en = (state == REQ);

  // Frame sequencer; tx is loaded one cycle ahead so the line changes exactly on state edges
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byte_count <= '0;
      shift_reg  <= '0;
      bit_timer  <= '0;
      bit_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (enable && !fifo_empty) begin
            state <= REQ;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          shift_reg <= fifo_rd_data;
          tx        <= 1'b0;
          bit_timer <= TIMER_RELOAD;
          state     <= START;
        end
        START: begin
          if (bit_timer == 8'd0) begin
            state     <= DATA;
            tx        <= shift_reg[0];
            bit_timer <= TIMER_RELOAD;
            bit_idx   <= '0;
          end else begin
            bit_timer <= bit_timer - 8'd1;
          end
        end
        DATA: begin
          if (bit_timer == 8'd0) begin
            bit_timer <= TIMER_RELOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // shift_reg[1] becomes shift_reg[0] after this shift, so tx tracks shift_reg[0]
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer - 8'd1;
          end
        end
        STOP: begin
          if (bit_timer == 8'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            byte_count <= byte_count + 8'd1;
          end else begin
            bit_timer <= bit_timer - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
